// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester shared register arbiter.
package arb_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arb_state_t;

  typedef enum logic {
    SRV_A = 1'b0,
    SRV_B = 1'b1
  } served_t;

  // Saturating increment of the ownership counter.
  function automatic logic [3:0] hold_next(input logic [3:0] cnt, input logic [3:0] lim);
    return (cnt >= lim) ? lim : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_shared_reg.sv
// Storage for the shared register: synchronous clear, load enable and
// a complemented view of the contents.
module shared_reg #(
  parameter int WIDTH = arb_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] not_q
);

  // Clear wins over load; otherwise load or hold.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

  // Complement is purely combinational.
  always_comb begin
    not_q = ~q;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Two-requester arbiter for a single shared register.
//
// state | meaning
// IDLE  | nobody owns the register
// OWN_A | requester A holds the grant and may write
// OWN_B | requester B holds the grant and may write
//
// Ties from IDLE go to whoever was not served last. An owner that keeps
// requesting while the other side waits is forced off after MAX_HOLD
// cycles. Writes are qualified by the registered grant, so a write at a
// handover edge still comes from the outgoing owner.
module shared_reg_arbiter #(
  parameter int WIDTH    = arb_pkg::DEF_WIDTH,
  parameter int MAX_HOLD = arb_pkg::DEF_MAX_HOLD
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_A,
  input  logic             REQ_B,
  input  logic             WE_A,
  input  logic             WE_B,
  input  logic [WIDTH-1:0] DIN_A,
  input  logic [WIDTH-1:0] DIN_B,
  output logic             GNT_A,
  output logic             GNT_B,
  output logic             DENY_A,
  output logic             DENY_B,
  output logic             BUSY,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NotQ
);
  import arb_pkg::*;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  served_t          last_q, last_d;
  logic             deny_a_q, deny_b_q;
  logic             gnt_a, gnt_b;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  assign gnt_a = (state_q == OWN_A);
  assign gnt_b = (state_q == OWN_B);

  // Next state, hold counter and last-served bookkeeping.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (REQ_A && REQ_B) begin
          state_d = (last_q == SRV_B) ? OWN_A : OWN_B;
        end else if (REQ_A) begin
          state_d = OWN_A;
        end else if (REQ_B) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (!REQ_A) begin
          state_d = REQ_B ? OWN_B : IDLE;
        end else if (REQ_B && (hold_q == HOLD_LIM)) begin
          state_d = OWN_B;
        end
      end
      OWN_B: begin
        if (!REQ_B) begin
          state_d = REQ_A ? OWN_A : IDLE;
        end else if (REQ_A && (hold_q == HOLD_LIM)) begin
          state_d = OWN_A;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == IDLE) || (state_d != state_q)) begin
      hold_d = 4'd0;
    end else begin
      hold_d = hold_next(hold_q, HOLD_LIM);
    end

    if ((state_d == OWN_A) && (state_q != OWN_A)) begin
      last_d = SRV_A;
    end else if ((state_d == OWN_B) && (state_q != OWN_B)) begin
      last_d = SRV_B;
    end
  end

  // State register; reset leaves B as last served so A wins the first tie.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      hold_q   <= 4'd0;
      last_q   <= SRV_B;
      deny_a_q <= 1'b0;
      deny_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      deny_a_q <= WE_A & ~gnt_a;
      deny_b_q <= WE_B & ~gnt_b;
    end
  end

  // Write mux: only the current grant holder can load the register.
  always_comb begin
    wr_en   = (gnt_a & WE_A) | (gnt_b & WE_B);
    wr_data = gnt_a ? DIN_A : DIN_B;
  end

  shared_reg #(.WIDTH(WIDTH)) u_shared_reg (
    .clk   (CLK),
    .clr_n (RST_N),
    .load  (wr_en),
    .d     (wr_data),
    .q     (Q),
    .not_q (NotQ)
  );

  assign GNT_A  = gnt_a;
  assign GNT_B  = gnt_b;
  assign DENY_A = deny_a_q;
  assign DENY_B = deny_b_q;
  assign BUSY   = gnt_a | gnt_b;

endmodule
